// File: rtl/mmio_input_ctrl_pkg.sv
// CpuPkg: shared CPU-side types plus the register map and button FSM state type of the
// memory-mapped input controller.
//   type_CpuData   32-bit CPU data word (wdata/rdata)
//   type_BtnState  debounce FSM states
//   IO_OFS_*       byte offsets of the input-controller registers from P_BASE_ADDR
package CpuPkg;

  typedef logic [31:0] type_CpuData;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } type_BtnState;

  localparam logic [7:0] IO_OFS_SW    = 8'h00;
  localparam logic [7:0] IO_OFS_LEVEL = 8'h04;
  localparam logic [7:0] IO_OFS_EVENT = 8'h08;
  localparam logic [7:0] IO_OFS_PCNT  = 8'h0c;
  localparam logic [7:0] IO_OFS_IMASK = 8'h10;

endpackage

// File: rtl/mmio_input_ctrl_debounce.sv
// btn_debounce: 2-flop synchroniser, four-state debounce FSM and 16-bit hold counter.
//   clk, rst  clock, asynchronous active-high reset
//   btn       raw button level (1 = pressed)
//   level     debounced level: 1 in PRESSED or RELEASE_WAIT
//   press     one-cycle pulse when a press is accepted
//   rel       one-cycle pulse when a release is accepted ('release' is a keyword)
module btn_debounce
  import CpuPkg::*;
#(
  parameter int unsigned P_DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press,
  output logic rel
);

  // Accept when the incremented count reaches P-1: together with the cycle that
  // launched the WAIT state, the synchronised level has then held P cycles.
  localparam logic [15:0] CntLast = 16'(P_DEBOUNCE_CYCLES - 1);

  logic [1:0]   sync_q;
  logic         btn_sync;
  type_BtnState state_q, state_d;
  logic [15:0]  cnt_q, cnt_d, cnt_inc;

  assign btn_sync = sync_q[1];
  assign cnt_inc  = cnt_q + 16'd1;
  assign level    = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press   = 1'b0;
    rel     = 1'b0;
    case (state_q)
      RELEASED: begin
        if (btn_sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_inc == CntLast) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_inc == CntLast) begin
          state_d = RELEASED;
          cnt_d   = '0;
          rel     = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/mmio_input_ctrl.sv
// mmio_input_ctrl: memory-mapped switch/button input controller on the CPU data port.
// Optional feature macro: IO_IRQ_EN (adds IMASK at +0x10 and the registered irq output).
//   clk, rst   clock, asynchronous active-high reset
//   sw         raw switch levels (synchronised into SW)
//   btnc       raw centre button (debounced)
//   addr       CPU byte address; we/wdata write strobe and data
//   hit        address falls in this block's register window
//   rdata      combinational read data (0 when not hit or unmapped offset)
//   irq        level interrupt (IO_IRQ_EN only)
module mmio_input_ctrl
  import CpuPkg::*;
#(
  parameter logic [31:0] P_BASE_ADDR       = 32'h0000_7f00,
  parameter int unsigned P_DEBOUNCE_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw,
  input  logic        btnc,
  input  logic [31:0] addr,
  input  logic        we,
  input  type_CpuData wdata,
  output logic        hit,
  output type_CpuData rdata
`ifdef IO_IRQ_EN
  ,
  output logic        irq
`endif
);

  logic [15:0] sw_meta_q, sw_q;
  logic [1:0]  event_q, event_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        level, press, rel;
  logic        win_hit;
  logic [7:0]  ofs;
  logic        wr_event, wr_pcnt;
  logic        unused_wdata;

  assign unused_wdata = ^wdata[31:2];

  btn_debounce #(
    .P_DEBOUNCE_CYCLES(P_DEBOUNCE_CYCLES)
  ) u_deb (
    .clk  (clk),
    .rst  (rst),
    .btn  (btnc),
    .level(level),
    .press(press),
    .rel  (rel)
  );

  assign win_hit  = (addr[31:4] == P_BASE_ADDR[31:4]);
  assign ofs      = {4'h0, addr[3:0]};
  assign wr_event = we & win_hit & (ofs == IO_OFS_EVENT);
  assign wr_pcnt  = we & win_hit & (ofs == IO_OFS_PCNT);

  // Set wins over W1C; a press coincident with a PCNT write counts from zero.
  always_comb begin
    event_d = (event_q & ~(wr_event ? wdata[1:0] : 2'b00)) | {rel, press};
    pcnt_d  = wr_pcnt ? 16'd0 : pcnt_q;
    if (press) begin
      pcnt_d = pcnt_d + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta_q <= '0;
      sw_q      <= '0;
      event_q   <= '0;
      pcnt_q    <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_q      <= sw_meta_q;
      event_q   <= event_d;
      pcnt_q    <= pcnt_d;
    end
  end

`ifdef IO_IRQ_EN
  logic       imask_hit;
  logic [1:0] imask_q;
  logic       irq_q;

  // IMASK sits just past the 16-byte window, so it gets its own exact-address match.
  assign imask_hit = (addr == (P_BASE_ADDR + {24'h0, IO_OFS_IMASK}));
  assign hit       = win_hit | imask_hit;
  assign irq       = irq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imask_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (we && imask_hit) begin
        imask_q <= wdata[1:0];
      end
      irq_q <= |(event_q & imask_q);
    end
  end
`else
  assign hit = win_hit;
`endif

  always_comb begin
    rdata = '0;
    if (win_hit) begin
      case (ofs)
        IO_OFS_SW:    rdata = {16'h0, sw_q};
        IO_OFS_LEVEL: rdata = {31'h0, level};
        IO_OFS_EVENT: rdata = {30'h0, event_q};
        IO_OFS_PCNT:  rdata = {16'h0, pcnt_q};
        default:      rdata = '0;
      endcase
    end
`ifdef IO_IRQ_EN
    if (imask_hit) begin
      rdata = {30'h0, imask_q};
    end
`endif
  end

endmodule

// File: tb/tb_mmio_input_ctrl.sv
// Directed self-checking bench for mmio_input_ctrl with a 4-cycle debounce.
module tb_mmio_input_ctrl;
  import CpuPkg::*;

  localparam logic [31:0] BASE = 32'h0000_7f00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sw = '0;
  logic        btnc = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  type_CpuData wdata = '0;
  logic        hit;
  type_CpuData rdata;
`ifdef IO_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  mmio_input_ctrl #(
    .P_BASE_ADDR      (BASE),
    .P_DEBOUNCE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .sw   (sw),
    .btnc (btnc),
    .addr (addr),
    .we   (we),
    .wdata(wdata),
    .hit  (hit),
    .rdata(rdata)
`ifdef IO_IRQ_EN
    ,
    .irq  (irq)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns after it.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [7:0] ofs, output logic [31:0] d);
    addr = BASE + {24'h0, ofs};
    #1;
    d = rdata;
  endtask

  task automatic wr(input logic [7:0] ofs, input logic [31:0] d);
    addr  = BASE + {24'h0, ofs};
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [7:0]  ofs_list [5] = '{8'h00, 8'h04, 8'h08, 8'h0c, 8'h10};
    rst  = 1'b1;
    btnc = 1'b1;
    sw   = 16'hffff;
    step(3);
    foreach (ofs_list[i]) begin
      rd(ofs_list[i], d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL reset_rd[%0h]: got %h want 00000000", ofs_list[i], d);
      end
    end
`ifdef IO_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %b want 0", irq);
    end
`endif
    sw  = 16'h0;
    rst = 1'b0;
    // Edge k is the first edge sampling btnc; LEVEL must appear after edge k+5, not before.
    step(5);
    rd(IO_OFS_LEVEL, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_level_early: got %h want 00000000", d);
    end
    step();
    rd(IO_OFS_LEVEL, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL reset_level: got %h want 00000001", d);
    end
    rd(IO_OFS_EVENT, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL reset_press_event: got %h want 00000001", d);
    end
    // Symmetric release latency.
    btnc = 1'b0;
    step(5);
    rd(IO_OFS_LEVEL, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL release_level_early: got %h want 00000001", d);
    end
    step();
    rd(IO_OFS_EVENT, d);
    checks++;
    if (d !== 32'h3) begin
      errors++;
      $display("FAIL release_event: got %h want 00000003", d);
    end
    wr(IO_OFS_EVENT, 32'h3);
    wr(IO_OFS_PCNT, 32'h0);
    rd(IO_OFS_PCNT, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL pcnt_clear: got %h want 00000000", d);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    btnc = 1'b1;
    step(2);
    btnc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rd(IO_OFS_LEVEL, d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL glitch_level@%0d: got %h want 00000000", i, d);
      end
      rd(IO_OFS_EVENT, d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL glitch_event@%0d: got %h want 00000000", i, d);
      end
      rd(IO_OFS_PCNT, d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL glitch_pcnt@%0d: got %h want 00000000", i, d);
      end
      step();
    end
  endtask

  task automatic test_press_release();
    logic [31:0] d;
    btnc = 1'b1;
    step(20);
    btnc = 1'b0;
    step(10);
    rd(IO_OFS_EVENT, d);
    checks++;
    if (d !== 32'h3) begin
      errors++;
      $display("FAIL pr_event: got %h want 00000003", d);
    end
    rd(IO_OFS_PCNT, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL pr_pcnt: got %h want 00000001", d);
    end
    wr(IO_OFS_EVENT, 32'h1);
    rd(IO_OFS_EVENT, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL pr_w1c: got %h want 00000002", d);
    end
    wr(IO_OFS_EVENT, 32'h2);
  endtask

  task automatic test_collisions();
    logic [31:0] d;
    // Press pulse lands on edge k+5; the W1C write rides that same edge.
    btnc = 1'b1;
    step(5);
    wr(IO_OFS_EVENT, 32'h1);
    rd(IO_OFS_EVENT, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL coll_w1c: got %h want 00000001", d);
    end
    rd(IO_OFS_PCNT, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL coll_pcnt2: got %h want 00000002", d);
    end
    btnc = 1'b0;
    step(10);
    wr(IO_OFS_EVENT, 32'h3);
    btnc = 1'b1;
    step(5);
    wr(IO_OFS_PCNT, 32'h0);
    rd(IO_OFS_PCNT, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL coll_pcnt_wr: got %h want 00000001", d);
    end
    btnc = 1'b0;
    step(10);
    wr(IO_OFS_EVENT, 32'h3);
  endtask

  task automatic test_wrap_decode();
    logic [31:0] d;
    force dut.pcnt_q = 16'hffff;
    step();
    release dut.pcnt_q;
    rd(IO_OFS_PCNT, d);
    checks++;
    if (d !== 32'hffff) begin
      errors++;
      $display("FAIL wrap_preset: got %h want 0000ffff", d);
    end
    btnc = 1'b1;
    step(8);
    rd(IO_OFS_PCNT, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pcnt: got %h want 00000000", d);
    end
    btnc = 1'b0;
    step(10);
    wr(IO_OFS_EVENT, 32'h3);
    rd(8'h20, d);
    checks++;
    if (hit !== 1'b0 || d !== 32'h0) begin
      errors++;
      $display("FAIL miss_decode: got hit=%b rdata=%h want hit=0 rdata=00000000", hit, d);
    end
    rd(IO_OFS_LEVEL, d);
    checks++;
    if (hit !== 1'b1) begin
      errors++;
      $display("FAIL hit_decode: got %b want 1", hit);
    end
    sw = 16'h0002;
    step(2);
    rd(IO_OFS_SW, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL sw_0002: got %h want 00000002", d);
    end
    sw = 16'ha5c3;
    step(2);
    wr(IO_OFS_SW, 32'hffff_ffff);
    rd(IO_OFS_SW, d);
    checks++;
    if (d !== 32'ha5c3) begin
      errors++;
      $display("FAIL sw_a5c3: got %h want 0000a5c3", d);
    end
  endtask

`ifdef IO_IRQ_EN
  task automatic test_irq();
    logic [31:0] d;
    wr(IO_OFS_IMASK, 32'h1);
    rd(IO_OFS_IMASK, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL imask_rd: got %h want 00000001", d);
    end
    btnc = 1'b1;
    step(6);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_early: got %b want 0", irq);
    end
    step();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set: got %b want 1", irq);
    end
    wr(IO_OFS_EVENT, 32'h1);
    step();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear: got %b want 0", irq);
    end
    btnc = 1'b0;
    step(10);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_masked_release: got %b want 0", irq);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_glitch();
    test_press_release();
    test_collisions();
    test_wrap_decode();
`ifdef IO_IRQ_EN
    test_irq();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
